pico_wb_master_bridge: RTL and testbench
========================================

Name: pico_wb_master_bridge

Overview:
Converts the PicoRV32 native memory interface (mem_valid/mem_ready handshake) into single Wishbone classic master cycles. It sits directly upstream of the Wishbone RAM and peripheral slaves in PicoSoC_Wishbone. It adds a bus-error path and a no-ack timeout, so the core never hangs on an unmapped address.

Parameters:
TIMEOUT_CYCLES, 255, cycles in ACCESS without ack/err before forced termination; 0 disables the timeout.
ERR_RDATA, 32'hDEAD_BEEF, read data returned to the core on an error or timeout termination.

Ports:
wb_clk_i  input  1  system clock; all logic on the rising edge.
wb_rst_i  input  1  reset, asynchronous, active-high.
mem_valid  input  1  core request valid.
mem_instr  input  1  request is an instruction fetch.
mem_addr  input  32  byte address.
mem_wdata  input  32  write data.
mem_wstrb  input  4  byte write strobes; 0 = read.
mem_ready  output  1  one-cycle completion pulse to the core.
mem_rdata  output  32  read data to the core.
wbm_adr_o  output  32  Wishbone address (byte address, passed unchanged).
wbm_dat_o  output  32  Wishbone write data.
wbm_sel_o  output  4  byte selects.
wbm_we_o  output  1  write enable.
wbm_cyc_o  output  1  cycle.
wbm_stb_o  output  1  strobe.
wbm_dat_i  input  32  slave read data.
wbm_ack_i  input  1  slave acknowledge.
wbm_err_i  input  1  slave error.
wbm_instr_o  output  1  registered mem_instr; feeds the slave's mem_instr input.
bus_error  output  1  sticky flag: an err termination occurred.
bus_timeout  output  1  sticky flag: a timeout termination occurred.

Behaviour:
- Reset is asynchronous, active-high. Every output resets to 0; state resets to IDLE; timeout counter resets to 0. Reset asserted mid-cycle drops cyc/stb immediately, and the pending request is lost.
- FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - On mem_valid=1, register the request fields: adr = mem_addr, dat = mem_wdata, we = |mem_wstrb, instr = mem_instr.
  - sel = mem_wstrb for writes, 4'hF for reads.
  - Assert cyc/stb on the next edge, clear the counter, go to ACCESS.
- ACCESS:
  - adr/dat/sel/we/cyc/stb stay stable until termination.
  - The counter increments every cycle.
  - A termination event is ack_i, err_i, or counter == TIMEOUT_CYCLES-1 with TIMEOUT_CYCLES != 0. On the edge that samples it: drop cyc/stb and we, set mem_ready=1, go to RESP.
  - ack_i termination: reads load mem_rdata <= wbm_dat_i; writes leave mem_rdata unchanged.
  - err_i termination: reads load ERR_RDATA; set bus_error.
  - timeout termination: reads load ERR_RDATA; set bus_timeout.
- Simultaneous events: err_i beats ack_i; ack_i or err_i beats timeout in the same cycle.
- RESP: mem_ready=1 for exactly this cycle; mem_valid is ignored; next state is IDLE. mem_ready is 0 in all other states.
- Latency: mem_valid seen at edge N → cyc/stb high after N+1 → ack sampled at edge K → mem_ready high for the cycle after K. With a slave that acks one cycle after stb, mem_ready rises 3 cycles after mem_valid.
- A request still held on mem_valid when the FSM returns to IDLE is treated as a new request. The core drops mem_valid after mem_ready.
- mem_rdata holds its last value between transactions.
- bus_error and bus_timeout clear only on reset.
- Stray ack_i/err_i in IDLE or RESP are ignored.

Decomposition:
- Package pico_wb_pkg holds:
  - the state enum (IDLE, ACCESS, RESP);
  - constant WB_SEL_ALL = 4'hF;
  - constant ERR_RDATA_DEFAULT = 32'hDEAD_BEEF.
- Sub-module pico_wb_timeout holds the counter with parameter TIMEOUT_CYCLES.
  - Inputs: clear, enable.
  - Output: expired.
  - Width is $clog2(TIMEOUT_CYCLES+1), minimum 1.

Test Plan:
- Read at 0x0000_0010, slave acks 1 cycle after stb with 0x1234_5678 → wbm_sel_o=4'hF, we=0; mem_rdata=0x1234_5678; mem_ready high exactly 1 cycle, 3 cycles after mem_valid.
- Write 0xAABB_CCDD, wstrb=4'b0010, to 0x1000_0000 → wbm_sel_o=4'b0010, wbm_we_o=1, wbm_dat_o=0xAABB_CCDD stable until ack; mem_rdata unchanged.
- Read answered with err_i=1 (ack_i also 1 in the same cycle) → mem_rdata=0xDEAD_BEEF; bus_error=1 and stays 1 through a later good access.
- TIMEOUT_CYCLES=8, slave silent → cyc/stb high exactly 8 cycles; mem_ready pulses; mem_rdata=0xDEAD_BEEF; bus_timeout=1. With TIMEOUT_CYCLES=0, still waiting after 1000 cycles.
- Reset asserted mid-ACCESS (not on a clock edge) → cyc/stb/mem_ready drop to 0 immediately. After release, a new read completes normally.
- Two back-to-back reads, mem_instr=1 then 0 → wbm_instr_o tracks each request; two distinct Wishbone cycles with cyc low for at least 1 cycle between them.

Source files
------------

// File: rtl/pico_wb_pkg.sv
// Shared types and constants for the PicoRV32-to-Wishbone master bridge.
package pico_wb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StResp
  } wb_state_e;

  localparam logic [3:0]  WB_SEL_ALL        = 4'hF;
  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/pico_wb_timeout.sv
// No-ack watchdog: counts cycles spent in ACCESS and flags the last allowed one.
module pico_wb_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = (TIMEOUT_CYCLES == 0) ? '0 : CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero limit disables the watchdog entirely.
  assign expired_o = (TIMEOUT_CYCLES != 0) && enable_i && (cnt_q == CntLast);

endmodule

// File: rtl/pico_wb_master_bridge.sv
// PicoRV32 native memory port to single Wishbone classic master cycles,
// with bus-error reporting and a no-ack timeout.
module pico_wb_master_bridge
  import pico_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic        wbm_instr_o,
  output logic        bus_error,
  output logic        bus_timeout
);

  wb_state_e   state_q, state_d;
  logic [31:0] adr_q, dat_q, rdata_q;
  logic [3:0]  sel_q;
  logic        we_q, instr_q, err_q, to_q;

  logic in_access, expired;
  logic term_ack, term_err, term_to, term_any;

  assign in_access = (state_q == StAccess);

  pico_wb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (wb_clk_i),
    .rst_i    (wb_rst_i),
    .clear_i  (state_q == StIdle),
    .enable_i (in_access),
    .expired_o(expired)
  );

  // Priority: err over ack, either over timeout.
  assign term_err = in_access && wbm_err_i;
  assign term_ack = in_access && wbm_ack_i && !wbm_err_i;
  assign term_to  = in_access && expired && !wbm_ack_i && !wbm_err_i;
  assign term_any = term_err || term_ack || term_to;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (mem_valid) state_d = StAccess;
      StAccess: if (term_any) state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    wbm_cyc_o = in_access;
    wbm_stb_o = in_access;
    wbm_we_o  = in_access && we_q;
    mem_ready = (state_q == StResp);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      instr_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      if (state_q == StIdle && mem_valid) begin
        adr_q   <= mem_addr;
        dat_q   <= mem_wdata;
        we_q    <= |mem_wstrb;
        sel_q   <= (|mem_wstrb) ? mem_wstrb : WB_SEL_ALL;
        instr_q <= mem_instr;
      end
      // Writes keep the previous read data visible to the core.
      if (term_any && !we_q) begin
        rdata_q <= term_ack ? wbm_dat_i : ERR_RDATA;
      end
      if (term_err) err_q <= 1'b1;
      if (term_to)  to_q  <= 1'b1;
    end
  end

  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = dat_q;
  assign wbm_sel_o   = sel_q;
  assign wbm_instr_o = instr_q;
  assign mem_rdata   = rdata_q;
  assign bus_error   = err_q;
  assign bus_timeout = to_q;

endmodule

// File: tb/tb_pico_wb_master_bridge.sv
// Self-checking bench for pico_wb_master_bridge: table of transactions against a
// behavioural Wishbone slave, scoreboarded read data, plus reset/back-to-back/no-timeout cases.
module tb_pico_wb_master_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i, wbm_err_i, wbm_instr_o;
  logic        bus_error, bus_timeout;

  // Second instance with the watchdog disabled.
  logic        z_valid, z_ready, z_we, z_cyc, z_stb, z_instr, z_err, z_to, z_ready_seen;
  logic [31:0] z_rdata, z_adr, z_dat;
  logic [3:0]  z_sel;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pico_wb_master_bridge #(.TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
    .wbm_err_i(wbm_err_i), .wbm_instr_o(wbm_instr_o), .bus_error(bus_error),
    .bus_timeout(bus_timeout)
  );

  pico_wb_master_bridge #(.TIMEOUT_CYCLES(0)) dut_nto (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .mem_valid(z_valid), .mem_instr(1'b0), .mem_addr(32'h0000_0800),
    .mem_wdata(32'h0), .mem_wstrb(4'h0), .mem_ready(z_ready),
    .mem_rdata(z_rdata), .wbm_adr_o(z_adr), .wbm_dat_o(z_dat),
    .wbm_sel_o(z_sel), .wbm_we_o(z_we), .wbm_cyc_o(z_cyc),
    .wbm_stb_o(z_stb), .wbm_dat_i(32'h0), .wbm_ack_i(1'b0),
    .wbm_err_i(1'b0), .wbm_instr_o(z_instr), .bus_error(z_err),
    .bus_timeout(z_to)
  );

  // Slave: 0 = ack, 1 = ack+err together, 2 = silent, 3 = err only; answers one cycle after stb.
  int          slv_mode;
  logic [31:0] slv_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wbm_ack_i <= 1'b0;
      wbm_err_i <= 1'b0;
      wbm_dat_i <= 32'h0;
    end else begin
      wbm_ack_i <= 1'b0;
      wbm_err_i <= 1'b0;
      if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i && !wbm_err_i) begin
        case (slv_mode)
          0: begin wbm_ack_i <= 1'b1; wbm_dat_i <= slv_data; end
          1: begin wbm_ack_i <= 1'b1; wbm_err_i <= 1'b1; wbm_dat_i <= slv_data; end
          3: begin wbm_err_i <= 1'b1; wbm_dat_i <= slv_data; end
          default: ;
        endcase
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) z_ready_seen <= 1'b0;
    else if (z_ready) z_ready_seen <= 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } exp_t;

  exp_t sb[$];

  always @(negedge clk) begin
    if (!rst && mem_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_unexpected_ready: got ready=1 expected no pending request");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_rdata", mem_rdata, e.rdata);
        check("sb_bus_error", bus_error, e.err);
        check("sb_bus_timeout", bus_timeout, e.to);
      end
    end
  end

  typedef struct {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          mode;
    logic [31:0] sdata;
    logic [3:0]  exp_sel;
    logic        exp_we;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_to;
    int          exp_cyc;
    int          exp_lat;
  } vec_t;

  function automatic vec_t mk(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, input int mode, input logic [31:0] sdata,
                              input logic [3:0] exp_sel, input logic exp_we,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input logic exp_to, input int exp_cyc, input int exp_lat);
    vec_t v;
    v.instr = instr; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb; v.mode = mode;
    v.sdata = sdata; v.exp_sel = exp_sel; v.exp_we = exp_we; v.exp_rdata = exp_rdata;
    v.exp_err = exp_err; v.exp_to = exp_to; v.exp_cyc = exp_cyc; v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int          lat = 0;
    int          ncyc = 0;
    logic        stable = 1'b1;
    logic        seen = 1'b0;
    logic        got_ready = 1'b0;
    logic [31:0] adr0, dat0;
    logic [3:0]  sel0;
    logic        we0;
    exp_t        e;
    @(posedge clk);
    #1;
    slv_mode  = v.mode;
    slv_data  = v.sdata;
    mem_valid = 1'b1;
    mem_instr = v.instr;
    mem_addr  = v.addr;
    mem_wdata = v.wdata;
    mem_wstrb = v.wstrb;
    e.rdata = v.exp_rdata; e.err = v.exp_err; e.to = v.exp_to;
    sb.push_back(e);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_ready) begin
        got_ready = 1'b1;
        break;
      end
      lat++;
      if (wbm_cyc_o) begin
        ncyc++;
        if (!seen) begin
          seen = 1'b1;
          adr0 = wbm_adr_o; dat0 = wbm_dat_o; sel0 = wbm_sel_o; we0 = wbm_we_o;
          check("adr", wbm_adr_o, v.addr);
          check("sel", wbm_sel_o, v.exp_sel);
          check("we", wbm_we_o, v.exp_we);
          check("stb", wbm_stb_o, 1'b1);
          check("instr", wbm_instr_o, v.instr);
          if (v.exp_we) check("dat", wbm_dat_o, v.wdata);
        end else if (wbm_adr_o !== adr0 || wbm_dat_o !== dat0 || wbm_sel_o !== sel0 ||
                     wbm_we_o !== we0 || !wbm_stb_o) begin
          stable = 1'b0;
        end
      end
    end
    mem_valid = 1'b0;
    check("ready_reached", got_ready, 1'b1);
    check("bus_stable", stable, 1'b1);
    check("cyc_cycles", ncyc, v.exp_cyc);
    check("ready_latency", lat, v.exp_lat);
    check("cyc_low_at_ready", wbm_cyc_o, 1'b0);
    @(negedge clk);
    check("ready_one_cycle", mem_ready, 1'b0);
  endtask

  vec_t vecs[7];

  initial begin
    logic        ok;
    int          gap;
    exp_t        e;

    vecs[0] = mk(1'b1, 32'h0000_0010, 32'h0, 4'b0000, 0, 32'h1234_5678,
                 4'hF, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 2, 3);
    vecs[1] = mk(1'b0, 32'h1000_0000, 32'hAABB_CCDD, 4'b0010, 0, 32'h0BAD_F00D,
                 4'b0010, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 2, 3);
    vecs[2] = mk(1'b0, 32'h0000_0020, 32'h0, 4'b0000, 1, 32'h5555_5555,
                 4'hF, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 2, 3);
    vecs[3] = mk(1'b1, 32'h0000_0024, 32'h0, 4'b0000, 0, 32'hCAFE_F00D,
                 4'hF, 1'b0, 32'hCAFE_F00D, 1'b1, 1'b0, 2, 3);
    vecs[4] = mk(1'b0, 32'h0000_0030, 32'h0, 4'b0000, 2, 32'h0,
                 4'hF, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1, 8, 9);
    vecs[5] = mk(1'b0, 32'h0000_0040, 32'h1122_3344, 4'b1111, 3, 32'h7777_7777,
                 4'hF, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 2, 3);
    vecs[6] = mk(1'b1, 32'h0000_0044, 32'h0, 4'b0000, 0, 32'h0000_0001,
                 4'hF, 1'b0, 32'h0000_0001, 1'b1, 1'b1, 2, 3);

    rst = 1'b1;
    mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    z_valid = 1'b0;
    slv_mode = 0; slv_data = '0;
    repeat (3) @(posedge clk);
    #3;
    check("rst_cyc", wbm_cyc_o, 1'b0);
    check("rst_ready", mem_ready, 1'b0);
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_sel", wbm_sel_o, 4'h0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset mid-ACCESS, away from a clock edge.
    @(posedge clk);
    #1;
    slv_mode = 2;
    mem_valid = 1'b1; mem_instr = 1'b0; mem_addr = 32'h0000_0050; mem_wstrb = 4'h0;
    e.rdata = 32'hDEAD_BEEF; e.err = 1'b1; e.to = 1'b1;
    sb.push_back(e);
    repeat (3) @(posedge clk);
    check("pre_rst_cyc", wbm_cyc_o, 1'b1);
    #2;
    rst = 1'b1;
    mem_valid = 1'b0;
    sb.delete();
    #1;
    check("midrst_cyc", wbm_cyc_o, 1'b0);
    check("midrst_stb", wbm_stb_o, 1'b0);
    check("midrst_ready", mem_ready, 1'b0);
    check("midrst_bus_error", bus_error, 1'b0);
    check("midrst_bus_timeout", bus_timeout, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    run_vec(mk(1'b0, 32'h0000_0060, 32'h0, 4'b0000, 0, 32'h0F0F_0F0F,
               4'hF, 1'b0, 32'h0F0F_0F0F, 1'b0, 1'b0, 2, 3));

    // Back-to-back reads with mem_valid held: instr fetch then data read.
    @(posedge clk);
    #1;
    slv_mode = 0; slv_data = 32'h1111_1111;
    mem_valid = 1'b1; mem_instr = 1'b1; mem_addr = 32'h0000_0100; mem_wstrb = 4'h0;
    e.rdata = 32'h1111_1111; e.err = 1'b0; e.to = 1'b0;
    sb.push_back(e);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wbm_cyc_o) check("b2b_instr_first", wbm_instr_o, 1'b1);
      if (mem_ready) begin ok = 1'b1; break; end
    end
    check("b2b_first_ready", ok, 1'b1);
    mem_instr = 1'b0; mem_addr = 32'h0000_0104; slv_data = 32'h2222_2222;
    e.rdata = 32'h2222_2222;
    sb.push_back(e);
    gap = 1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wbm_cyc_o) begin ok = 1'b1; break; end
      gap++;
    end
    check("b2b_second_cyc", ok, 1'b1);
    check("b2b_gap_ge1", (gap >= 1), 1'b1);
    check("b2b_instr_second", wbm_instr_o, 1'b0);
    check("b2b_adr_second", wbm_adr_o, 32'h0000_0104);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_ready) begin ok = 1'b1; break; end
    end
    mem_valid = 1'b0;
    check("b2b_second_ready", ok, 1'b1);
    @(negedge clk);
    check("b2b_ready_drop", mem_ready, 1'b0);

    // Timeout disabled: a silent slave keeps the cycle open indefinitely.
    @(posedge clk);
    #1;
    z_valid = 1'b1;
    repeat (1001) @(posedge clk);
    #1;
    check("nto_cyc_held", z_cyc, 1'b1);
    check("nto_no_ready", z_ready_seen, 1'b0);
    check("nto_no_timeout_flag", z_to, 1'b0);
    z_valid = 1'b0;

    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
